countdown_timer_mux: RTL and testbench
======================================

# countdown_timer_mux

Parametrised countdown timer for the traffic light controller: loads a binary duration, counts down once per rising edge of the 1 Hz enable, and reports expiry to the controller FSM. It generalises the single-digit timer to N BCD digits with pause/resume, load clamping, and a time-multiplexed 7-segment driver with leading-zero blanking. It sits between the phase FSM (Start_Timer, Pause, Value, Expired) and the board's seven-segment display.

## Interface
- VALUE_W, 7: width of Value and Remaining.
- DIGITS, 2: number of displayed decimal digits (1..4).
- REFRESH_DIV, 100000: clk cycles each digit stays active.
- BLANK_LZ, 1: 1 blanks leading zero digits (units digit never blanked).
- clk  in  1  system clock, single domain.
- Sync_Reset  in  1  synchronous, active-high reset.
- Start_Timer  in  1  load Value and arm countdown; level, every high cycle reloads.
- Pause  in  1  hold count; ticks during pause are discarded.
- Value  in  VALUE_W  duration in seconds (binary).
- OneHz  in  1  1 Hz square wave, synchronous to clk; rising edge = tick.
- Expired  out  1  one-cycle pulse when the countdown completes.
- Running  out  1  high in RUN or PAUSED.
- Remaining  out  VALUE_W  current count (binary).
- Anode_Activate  out  DIGITS  active-low one-hot digit enable; bit 0 = units.
- LED_out  out  7  active-low segments {a,b,c,d,e,f,g}.

## Operation
- Tick: tick = OneHz & ~OneHz_q; OneHz_q is a register of OneHz, reset to 0.
- Load clamp: loaded count = min(Value, 10^DIGITS-1); e.g. Value=120, DIGITS=2 loads 99.
- States: IDLE, RUN, PAUSED, DONE. Reset -> IDLE.
- Any state, Start_Timer=1: count <= clamped Value, state <= RUN; ticks ignored that cycle. Start has priority over Pause and tick.
- RUN, Pause=1 -> PAUSED. PAUSED, Pause=0 -> RUN. A tick coinciding with Pause=1 is lost.
- RUN, Pause=0, tick, count>0: count <= count-1.
- RUN, Start_Timer=0, count==0: Expired=1 for exactly that cycle, state <= DONE. Covers both countdown completion and a load of 0.
- DONE, IDLE: count holds; ticks and Pause ignored; Running=0.
- Display: binary count converted to DIGITS BCD digits. Refresh counter counts 0..REFRESH_DIV-1; on wrap, digit index advances 0..DIGITS-1 and wraps. Selected digit's anode low, others high. LED_out decodes the selected BCD digit (0 = 7'b0000001, 1 = 7'b1001111, 3 = 7'b0000110, 9 = 7'b0000100). BLANK_LZ=1: a digit above units that is zero and has all higher digits zero outputs 7'b1111111.

## Timing
- Reset values: state IDLE, count 0, Remaining 0, Expired 0, Running 0, refresh counter 0, digit index 0, Anode_Activate = all ones except bit 0 low, LED_out 7'b0000001.
- Load: Start_Timer sampled high at edge N -> Remaining = Value (clamped) and Running=1 after edge N.
- Tick latency: OneHz first sampled high at edge N -> Remaining decremented after edge N.
- Expiry: count reaches 0 after edge N -> Expired high after edge N+1 for one cycle, Running low from the same edge.
- Value=0 load at edge N with Start_Timer low at N+1 -> Expired after edge N+1.
- Start_Timer held high: no countdown and no Expired until the first low cycle.
- Reset mid-count: all state returns to reset values at the next edge; no Expired pulse.
- Display: each digit active exactly REFRESH_DIV cycles; segment and anode change on the same edge; all outputs registered.

## Test plan
- Value=3, Start_Timer 6 cycles, four OneHz periods -> Remaining 3,2,1,0 on successive rising edges; one Expired pulse one cycle after 0; further ticks leave Remaining=0 with no pulse.
- Value=5, Pause high across two OneHz rising edges, then released -> Remaining stays 5 during pause; resumes 4,3,... after release; Expired after five counted ticks.
- Value=0 with Start_Timer pulse -> Expired exactly one cycle after Start_Timer falls; Running high for only that cycle.
- Value=120, DIGITS=2 -> Remaining=99; Start_Timer reasserted at count 40 reloads to 99 with no Expired.
- REFRESH_DIV=4, count=7, BLANK_LZ=1 -> Anode_Activate alternates 2'b10/2'b01 every 4 cycles; units LED_out=7'b0001111, tens 7'b1111111. BLANK_LZ=0 -> tens 7'b0000001.
- Sync_Reset asserted at count 2 in RUN -> next edge: Remaining 0, Running 0, Anode 2'b10, LED_out 7'b0000001, no Expired.

Source files
------------

// File: rtl/countdown_timer_mux.sv
// ============================================================================
// Module   : countdown_timer_mux
// Brief    : N-digit BCD countdown timer with pause, load clamp and a
//            time-multiplexed 7-segment driver with leading-zero blanking.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module countdown_timer_mux #(
    parameter int VALUE_W     = 7,
    parameter int DIGITS      = 2,
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_LZ    = 1
) (
    input  logic               clk,
    input  logic               Sync_Reset,
    input  logic               Start_Timer,
    input  logic               Pause,
    input  logic [VALUE_W-1:0] Value,
    input  logic               OneHz,
    output logic               Expired,
    output logic               Running,
    output logic [VALUE_W-1:0] Remaining,
    output logic [DIGITS-1:0]  Anode_Activate,
    output logic [6:0]         LED_out
);

    function automatic logic [31:0] pow10(input int n);
        logic [31:0] r;
        r = 32'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 32'd10;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    localparam logic [31:0] c_max_dec = pow10(DIGITS) - 32'd1;
    localparam int          c_ref_w   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int          c_dig_w   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [c_ref_w-1:0] c_ref_last = c_ref_w'(REFRESH_DIV - 1);
    localparam logic [c_dig_w-1:0] c_dig_last = c_dig_w'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t             r_state;
    logic [VALUE_W-1:0] r_count;
    logic               r_onehz_q;
    logic               r_expired;
    logic               r_running;
    logic               w_tick;
    logic [VALUE_W-1:0] w_load;

    assign w_tick = OneHz & ~r_onehz_q;
    assign w_load = (32'(Value) > c_max_dec) ? VALUE_W'(c_max_dec) : Value;

    // Start wins over everything; expiry at zero wins over a coincident Pause.
    always_ff @(posedge clk) begin
        if (Sync_Reset) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_onehz_q <= 1'b0;
            r_expired <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_onehz_q <= OneHz;
            r_expired <= 1'b0;
            if (Start_Timer) begin
                r_count   <= w_load;
                r_state   <= S_RUN;
                r_running <= 1'b1;
            end else begin
                case (r_state)
                    S_RUN: begin
                        if (r_count == '0) begin
                            r_expired <= 1'b1;
                            r_state   <= S_DONE;
                            r_running <= 1'b0;
                        end else if (Pause) begin
                            r_state <= S_PAUSED;
                        end else if (w_tick) begin
                            r_count <= r_count - 1'b1;
                        end
                    end
                    S_PAUSED: begin
                        if (!Pause) begin
                            r_state <= S_RUN;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign Expired   = r_expired;
    assign Running   = r_running;
    assign Remaining = r_count;

    // Binary to BCD by shift-and-add-3; the clamp keeps the count within DIGITS.
    logic [4*DIGITS-1:0] w_bcd;
    always_comb begin
        w_bcd = '0;
        for (int i = VALUE_W - 1; i >= 0; i--) begin
            for (int d = 0; d < DIGITS; d++) begin
                if (w_bcd[4*d +: 4] >= 4'd5) begin
                    w_bcd[4*d +: 4] = w_bcd[4*d +: 4] + 4'd3;
                end
            end
            w_bcd = {w_bcd[4*DIGITS-2:0], r_count[i]};
        end
    end

    logic [DIGITS-1:0] w_blank;
    logic              w_hi_zero;
    always_comb begin
        w_blank   = '0;
        w_hi_zero = 1'b1;
        for (int d = DIGITS - 1; d >= 1; d--) begin
            w_hi_zero  = w_hi_zero & (w_bcd[4*d +: 4] == 4'd0);
            w_blank[d] = w_hi_zero & (BLANK_LZ != 0);
        end
    end

    logic [c_ref_w-1:0] r_refresh;
    logic [c_dig_w-1:0] r_digit;
    logic [DIGITS-1:0]  r_anode;
    logic [6:0]         r_led;
    logic               w_ref_wrap;
    logic [c_dig_w-1:0] w_digit_nxt;
    logic [3:0]         w_sel_bcd;

    assign w_ref_wrap  = (r_refresh == c_ref_last);
    assign w_digit_nxt = !w_ref_wrap           ? r_digit :
                         (r_digit == c_dig_last) ? '0 : r_digit + 1'b1;
    assign w_sel_bcd   = w_bcd[4*w_digit_nxt +: 4];

    // Anode and segments are both derived from the next digit index so they
    // switch on the same edge.
    always_ff @(posedge clk) begin
        if (Sync_Reset) begin
            r_refresh <= '0;
            r_digit   <= '0;
            r_anode   <= ~DIGITS'(1);
            r_led     <= 7'b0000001;
        end else begin
            r_refresh <= w_ref_wrap ? '0 : r_refresh + 1'b1;
            r_digit   <= w_digit_nxt;
            r_anode   <= ~(DIGITS'(1) << w_digit_nxt);
            r_led     <= w_blank[w_digit_nxt] ? 7'b1111111 : seg7(w_sel_bcd);
        end
    end

    assign Anode_Activate = r_anode;
    assign LED_out        = r_led;

endmodule

`default_nettype wire

// File: tb/tb_countdown_timer_mux.sv
// ============================================================================
// Module   : tb_countdown_timer_mux
// Brief    : Randomised scoreboard bench for countdown_timer_mux against a
//            behavioural model (two instances: blanking on and off).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_countdown_timer_mux;

    localparam int VW     = 7;
    localparam int ND     = 2;
    localparam int DIV    = 4;
    localparam int HZ_HALF = 3;
    localparam int MAXC   = 99;

    typedef struct {
        logic [6:0] rem;
        logic       run;
        logic       exp;
        logic [1:0] an;
        logic [6:0] led1;
        logic [6:0] led0;
    } exp_t;

    logic          clk = 1'b1;
    logic          rst_s = 1'b0, start_s = 1'b0, pause_s = 1'b0, hz_s = 1'b0;
    logic [VW-1:0] val_s = '0;
    logic          exp1, run1, exp0, run0;
    logic [VW-1:0] rem1, rem0;
    logic [ND-1:0] an1, an0;
    logic [6:0]    led1, led0;

    always #5 clk = ~clk;

    countdown_timer_mux #(.VALUE_W(VW), .DIGITS(ND), .REFRESH_DIV(DIV), .BLANK_LZ(1)) dut1 (
        .clk(clk), .Sync_Reset(rst_s), .Start_Timer(start_s), .Pause(pause_s),
        .Value(val_s), .OneHz(hz_s), .Expired(exp1), .Running(run1),
        .Remaining(rem1), .Anode_Activate(an1), .LED_out(led1));

    countdown_timer_mux #(.VALUE_W(VW), .DIGITS(ND), .REFRESH_DIV(DIV), .BLANK_LZ(0)) dut0 (
        .clk(clk), .Sync_Reset(rst_s), .Start_Timer(start_s), .Pause(pause_s),
        .Value(val_s), .OneHz(hz_s), .Expired(exp0), .Running(run0),
        .Remaining(rem0), .Anode_Activate(an0), .LED_out(led0));

    exp_t sb[$];
    int   n_pass = 0, n_total = 0;
    bit   drv_done = 0;

    // Reference model: 0 idle, 1 run, 2 paused, 3 done
    int m_state = 0, m_count = 0, m_k = 0, hz_cnt = 0;
    bit m_prevhz = 0;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b0000001;  1: return 7'b1001111;
            2: return 7'b0010010;  3: return 7'b0000110;
            4: return 7'b1001100;  5: return 7'b0100100;
            6: return 7'b0100000;  7: return 7'b0001111;
            8: return 7'b0000000;  9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic int pw10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    task automatic model_step(input bit rst, input bit st, input bit pz, input int val, input bit hz);
        exp_t e;
        int   dig, dval;
        bit   tick;
        if (rst) begin
            m_state = 0; m_count = 0; m_prevhz = 0; m_k = 0;
            e.rem = '0; e.run = 0; e.exp = 0; e.an = 2'b10;
            e.led1 = 7'b0000001; e.led0 = 7'b0000001;
        end else begin
            m_k++;
            dig  = (m_k / DIV) % ND;
            // display reflects the count held before this edge
            dval = (m_count / pw10(dig)) % 10;
            e.an   = ~(2'b01 << dig);
            e.led0 = seg_of(dval);
            e.led1 = (dig > 0 && m_count < pw10(dig)) ? 7'b1111111 : seg_of(dval);
            tick = hz && !m_prevhz;
            m_prevhz = hz;
            e.exp = 0;
            if (st) begin
                m_count = (val > MAXC) ? MAXC : val;
                m_state = 1;
            end else if (m_state == 1 && m_count == 0) begin
                e.exp = 1; m_state = 3;
            end else if (m_state == 1 && pz) begin
                m_state = 2;
            end else if (m_state == 2 && !pz) begin
                m_state = 1;
            end else if (m_state == 1 && tick) begin
                m_count = m_count - 1;
            end
            e.rem = 7'(m_count);
            e.run = (m_state == 1 || m_state == 2);
        end
        sb.push_back(e);
    endtask

    task automatic cyc(input bit rst, input bit st, input bit pz, input int val);
        @(negedge clk);
        hz_cnt++;
        if (hz_cnt == HZ_HALF) begin
            hz_cnt = 0;
            hz_s = ~hz_s;
        end
        rst_s = rst; start_s = st; pause_s = pz; val_s = 7'(val);
        model_step(rst, st, pz, val, hz_s);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    endtask

    // Monitor: pops one expected record per clock edge
    initial begin
        exp_t e;
        while (!drv_done || sb.size() > 0) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                chk("scoreboard_underflow", 8'd1, 8'd0);
            end else begin
                e = sb.pop_front();
                chk("remaining",  {1'b0, rem1}, {1'b0, e.rem});
                chk("running",    {7'b0, run1}, {7'b0, e.run});
                chk("expired",    {7'b0, exp1}, {7'b0, e.exp});
                chk("anode",      {6'b0, an1},  {6'b0, e.an});
                chk("led_blank",  {1'b0, led1}, {1'b0, e.led1});
                chk("led_noblank",{1'b0, led0}, {1'b0, e.led0});
                chk("remaining_b",{1'b0, rem0}, {1'b0, e.rem});
            end
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Stimulus
    initial begin
        int guard;
        bit pz;
        repeat (2) cyc(1, 0, 0, 0);
        repeat (6) cyc(0, 1, 0, 3);
        repeat (36) cyc(0, 0, 0, 0);
        repeat (2) cyc(0, 1, 0, 5);
        repeat (8) cyc(0, 0, 0, 0);
        repeat (14) cyc(0, 0, 1, 0);
        repeat (45) cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 0);
        repeat (3) cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 120);
        guard = 0;
        while (m_count != 40 && guard < 1000) begin
            cyc(0, 0, 0, 0);
            guard++;
        end
        cyc(0, 1, 0, 120);
        repeat (20) cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 7);
        repeat (20) cyc(0, 0, 1, 0);
        cyc(0, 1, 0, 2);
        repeat (2) cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        repeat (4) cyc(0, 0, 0, 0);
        pz = 0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 19) == 0) pz = ~pz;
            cyc($urandom_range(0, 299) == 0, $urandom_range(0, 39) == 0, pz,
                int'($urandom_range(0, 127)));
        end
        drv_done = 1;
    end

    initial begin
        #500000;
        n_total++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("%0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
